pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Run/step/halt controller for the three-stage BRISC pipeline (fetch/decode, execute, writeback). It holds the pipeline idle until the UART program load completes, then either free-runs or advances one cycle per debounced button press. It squashes the wrong-path instruction behind a taken jump and counts advanced cycles for the seven-segment debug display. It sits at the processor top level and drives the advance enable of `PC_control`, `Instruction_register` and `execution_register`, plus the qualification of register-file and data-memory writes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a new `step_btn` level (10 ms at 100 MHz).
- `CNT_W`, default 16: width of `cycle_count`.

Ports:
- `CLK`  in  1  system clock; one clock domain.
- `RST`  in  1  reset, asynchronous, active-high.
- `load_done`  in  1  instruction memory loaded; level.
- `run_mode`  in  1  1 = free-run, 0 = single-step; from a switch, quasi-static.
- `halt_req`  in  1  level; while high, the pipeline must not advance.
- `step_btn`  in  1  raw, asynchronous, bouncing push-button.
- `jump_en_E`  in  1  taken jump resolved in execute this cycle.
- `pipe_en`  out  1  advance enable for PC, I/E register, E/W register and all W-stage writes.
- `ireg_flush`  out  1  load a NOP bubble into the I/E register at this edge.
- `state`  out  2  current FSM state, for debug.
- `cycle_count`  out  `CNT_W`  number of cycles with `pipe_en` high.

## Operation
- FSM states: IDLE=0, RUN=1, STEP=2, HALT=3.
- Transition priority is !`load_done` > `halt_req` > `run_mode`.
- IDLE:
  - `pipe_en`=0.
  - With `load_done`=1: go to HALT if `halt_req`, else to RUN if `run_mode`, else to STEP.
- RUN:
  - `pipe_en`=1.
  - !`load_done` → IDLE; `halt_req` → HALT; !`run_mode` → STEP.
- STEP:
  - `pipe_en` = `step_pulse`.
  - !`load_done` → IDLE; `halt_req` → HALT; `run_mode` → RUN.
- HALT:
  - `pipe_en`=0.
  - !`load_done` → IDLE; when !`halt_req`: `run_mode` ? RUN : STEP.
- `pipe_en` is decoded from the registered state and the registered `step_pulse` only. Therefore:
  - The edge that leaves RUN is still an advance edge.
  - No combinational path exists from `halt_req`, `run_mode` or `load_done` to `pipe_en`.
- `ireg_flush` = `pipe_en` & `jump_en_E`:
  - It is combinational.
  - It inserts exactly one bubble per taken jump.
  - With `pipe_en`=0 it is 0, and the jump stays pending in the execute stage until the next advance.
- `step_pulse`:
  - `step_btn` passes through a 2-FF synchronizer.
  - A counter counts consecutive cycles where the synchronized level ≠ the debounced level, and resets to 0 on any agreement.
  - The debounced level updates on the cycle the count reaches `DEBOUNCE_CYCLES`.
  - `step_pulse` is a one-cycle registered rising-edge detect of the debounced level.
  - A `step_pulse` outside STEP is discarded, never queued.
- `cycle_count`:
  - Increments by 1 on every edge with `pipe_en`=1 and wraps modulo 2^`CNT_W`.
  - Clears to 0 on the transition IDLE → any state, so that each new program load starts from zero.

## Timing
- Reset values: `state`=IDLE, `pipe_en`=0, `ireg_flush`=0, `cycle_count`=0. Synchronizer, debounced level, debounce counter and `step_pulse` all reset to 0.
- Deassertion of `load_done`, `halt_req` or `run_mode`:
  - Takes effect on `state` at the next edge.
  - `pipe_en` follows in the same cycle as `state`.
  - Latency is therefore 1 cycle.
- Button latency: a clean rise of `step_btn` held stable produces `step_pulse` (and `pipe_en` in STEP) for exactly 1 cycle, `DEBOUNCE_CYCLES`+3 cycles after the rise.
- A bounce shorter than `DEBOUNCE_CYCLES` stable cycles produces no pulse.
- If `step_pulse` and a state exit (e.g. `halt_req`) fall on the same cycle, the pulse still advances that cycle, because `pipe_en` uses the current state.
- `RST` asserted mid-program: all outputs return to reset values asynchronously; the FSM re-enters through IDLE.

## Structure
- Shared package `brisc_pkg`:
  - State encoding constants `SEQ_IDLE`, `SEQ_RUN`, `SEQ_STEP`, `SEQ_HALT`.
  - A 2-bit state typedef.
- One sub-module, `btn_debounce` (parameter `DEBOUNCE_CYCLES`):
  - Contains the synchronizer, the stability counter and the rising-edge pulse.
  - Reusable for the other `BTNS` inputs.
- The FSM, flush logic and cycle counter live in `pipeline_sequencer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset and load:** `RST` pulse with `load_done`=0 for 10 cycles → `state`=0, `pipe_en`=0, `cycle_count`=0. Raise `load_done` with `run_mode`=1 → `state`=1 next edge; after 20 cycles `cycle_count`=20.
- **Halt and resume:** in RUN, raise `halt_req` at cycle t → `pipe_en` high through edge t, `state`=3 at t+1. Drop it → RUN next edge; `cycle_count` frozen while halted.
- **Single step:** `run_mode`=0, clean `step_btn` rise held 10 cycles → exactly one `pipe_en` cycle, 7 cycles after the rise, and `cycle_count` +1. A 2-cycle glitch → no pulse.
- **Jump flush:** in RUN, `jump_en_E`=1 for one cycle → `ireg_flush`=1 in that cycle only. Same stimulus in HALT → `ireg_flush`=0.
- **Reload:** `load_done` falls while in RUN with `cycle_count`=37 → IDLE next edge. `load_done` rises → `cycle_count` reads 0 on entering RUN.
- **Async reset mid-step:** assert `RST` during debounce counting → outputs zero immediately; no `step_pulse` after release until a new stable press.

Source files
------------

// File: rtl/brisc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// brisc_pkg : shared BRISC types (sequencer state encoding)      rev 1.0
// ---------------------------------------------------------------------------
package brisc_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_STEP = 2'd2,
    SEQ_HALT = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce : 2-FF sync, stability debounce, one-cycle rise pulse  rev 1.0
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  // Level is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], btn};
      if (sync_ff[1] == level) begin
        cnt <= '0;
      end else if (cnt == LIMIT) begin
        level <= sync_ff[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_sequencer : run/step/halt control, jump flush, cycle counter rev 1.0
// ---------------------------------------------------------------------------
module pipeline_sequencer
  import brisc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_done,
  input  logic             run_mode,
  input  logic             halt_req,
  input  logic             step_btn,
  input  logic             jump_en_E,
  output logic             pipe_en,
  output logic             ireg_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  seq_state_t cur_state;
  seq_state_t nxt_state;
  logic       step_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk   (CLK),
    .rst   (RST),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_state <= SEQ_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    pipe_en   = 1'b0;
    unique case (cur_state)
      SEQ_IDLE: begin
        if (load_done) begin
          if (halt_req)      nxt_state = SEQ_HALT;
          else if (run_mode) nxt_state = SEQ_RUN;
          else               nxt_state = SEQ_STEP;
        end
      end
      SEQ_RUN: begin
        pipe_en = 1'b1;
        if (!load_done)     nxt_state = SEQ_IDLE;
        else if (halt_req)  nxt_state = SEQ_HALT;
        else if (!run_mode) nxt_state = SEQ_STEP;
      end
      SEQ_STEP: begin
        // A pulse arriving in any other state is simply dropped.
        pipe_en = step_pulse;
        if (!load_done)    nxt_state = SEQ_IDLE;
        else if (halt_req) nxt_state = SEQ_HALT;
        else if (run_mode) nxt_state = SEQ_RUN;
      end
      SEQ_HALT: begin
        if (!load_done)     nxt_state = SEQ_IDLE;
        else if (!halt_req) nxt_state = run_mode ? SEQ_RUN : SEQ_STEP;
      end
      default: nxt_state = SEQ_IDLE;
    endcase
  end

  // Jump stays pending in execute while stalled, so flush only on an advance.
  assign ireg_flush = pipe_en & jump_en_E;
  assign state      = cur_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_count <= '0;
    end else if (cur_state == SEQ_IDLE && nxt_state != SEQ_IDLE) begin
      cycle_count <= '0;
    end else if (pipe_en) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeline_sequencer : directed self-checking bench        rev 1.0
// ---------------------------------------------------------------------------
module tb_pipeline_sequencer;

  logic        CLK;
  logic        RST;
  logic        load_done;
  logic        run_mode;
  logic        halt_req;
  logic        step_btn;
  logic        jump_en_E;
  logic        pipe_en;
  logic        ireg_flush;
  logic [1:0]  state;
  logic [15:0] cycle_count;

  int tests_run;
  int tests_failed;

  pipeline_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .load_done   (load_done),
    .run_mode    (run_mode),
    .halt_req    (halt_req),
    .step_btn    (step_btn),
    .jump_en_E   (jump_en_E),
    .pipe_en     (pipe_en),
    .ireg_flush  (ireg_flush),
    .state       (state),
    .cycle_count (cycle_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; load_done = 1'b0; run_mode = 1'b0; halt_req = 1'b0;
    step_btn = 1'b0; jump_en_E = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", state); end
    tests_run++;
    if (pipe_en !== 1'b0) begin tests_failed++; $display("FAIL reset_pipe_en: got %b want 0", pipe_en); end
    tests_run++;
    if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    tests_run++;
    if (ireg_flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %b want 0", ireg_flush); end
    jump_en_E = 1'b0;
  endtask

  task automatic test_load_run();
    run_mode = 1'b1; load_done = 1'b1;
    tick();
    tests_run++;
    if (state !== 2'd1) begin tests_failed++; $display("FAIL load_state: got %0d want 1", state); end
    tests_run++;
    if (pipe_en !== 1'b1) begin tests_failed++; $display("FAIL load_pipe_en: got %b want 1", pipe_en); end
    tests_run++;
    if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL load_count: got %0d want 0", cycle_count); end
    repeat (20) tick();
    tests_run++;
    if (cycle_count !== 16'd20) begin tests_failed++; $display("FAIL run_count20: got %0d want 20", cycle_count); end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    #1;
    tests_run++;
    if (pipe_en !== 1'b1) begin tests_failed++; $display("FAIL halt_same_cycle_pipe: got %b want 1", pipe_en); end
    tick();
    tests_run++;
    if (state !== 2'd3) begin tests_failed++; $display("FAIL halt_state: got %0d want 3", state); end
    tests_run++;
    if (pipe_en !== 1'b0) begin tests_failed++; $display("FAIL halt_pipe_en: got %b want 0", pipe_en); end
    tests_run++;
    if (cycle_count !== 16'd21) begin tests_failed++; $display("FAIL halt_exit_edge_count: got %0d want 21", cycle_count); end
    repeat (5) tick();
    tests_run++;
    if (cycle_count !== 16'd21) begin tests_failed++; $display("FAIL halt_frozen_count: got %0d want 21", cycle_count); end
    halt_req = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd1 || pipe_en !== 1'b1) begin
      tests_failed++; $display("FAIL resume_run: got state %0d pipe %b want 1/1", state, pipe_en);
    end
    tests_run++;
    if (cycle_count !== 16'd21) begin tests_failed++; $display("FAIL resume_count: got %0d want 21", cycle_count); end
    tick();
    tests_run++;
    if (cycle_count !== 16'd22) begin tests_failed++; $display("FAIL resume_inc: got %0d want 22", cycle_count); end
  endtask

  task automatic test_jump();
    jump_en_E = 1'b1;
    #1;
    tests_run++;
    if (ireg_flush !== 1'b1) begin tests_failed++; $display("FAIL flush_run: got %b want 1", ireg_flush); end
    tick();
    jump_en_E = 1'b0;
    #1;
    tests_run++;
    if (ireg_flush !== 1'b0) begin tests_failed++; $display("FAIL flush_one_cycle: got %b want 0", ireg_flush); end
    halt_req = 1'b1;
    tick();
    jump_en_E = 1'b1;
    #1;
    tests_run++;
    if (ireg_flush !== 1'b0) begin tests_failed++; $display("FAIL flush_halt: got %b want 0", ireg_flush); end
    tick();
    jump_en_E = 1'b0;
    tests_run++;
    if (state !== 2'd3 || cycle_count !== 16'd24) begin
      tests_failed++; $display("FAIL jump_halt_hold: got state %0d count %0d want 3/24", state, cycle_count);
    end
  endtask

  task automatic test_step();
    int bad;
    run_mode = 1'b0; halt_req = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd2 || pipe_en !== 1'b0) begin
      tests_failed++; $display("FAIL step_enter: got state %0d pipe %b want 2/0", state, pipe_en);
    end
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests_run++;
      if (pipe_en !== (k == 7)) begin
        tests_failed++; $display("FAIL step_pulse_k%0d: got %b want %b", k, pipe_en, (k == 7));
      end
    end
    step_btn = 1'b0;
    tests_run++;
    if (cycle_count !== 16'd25) begin tests_failed++; $display("FAIL step_count: got %0d want 25", cycle_count); end
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pipe_en !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL step_release: got %0d advance cycles want 0", bad); end
    step_btn = 1'b1;
    tick();
    tick();
    step_btn = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pipe_en !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL step_glitch: got %0d advance cycles want 0", bad); end
    tests_run++;
    if (cycle_count !== 16'd25) begin tests_failed++; $display("FAIL glitch_count: got %0d want 25", cycle_count); end
  endtask

  task automatic test_reload();
    run_mode = 1'b1;
    tick();
    repeat (12) tick();
    tests_run++;
    if (state !== 2'd1 || cycle_count !== 16'd37) begin
      tests_failed++; $display("FAIL reload_pre: got state %0d count %0d want 1/37", state, cycle_count);
    end
    load_done = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd0 || pipe_en !== 1'b0 || cycle_count !== 16'd38) begin
      tests_failed++;
      $display("FAIL reload_idle: got state %0d pipe %b count %0d want 0/0/38", state, pipe_en, cycle_count);
    end
    tick();
    load_done = 1'b1;
    tick();
    tests_run++;
    if (state !== 2'd1 || cycle_count !== 16'd0) begin
      tests_failed++; $display("FAIL reload_clear: got state %0d count %0d want 1/0", state, cycle_count);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    run_mode = 1'b0;
    tick();
    step_btn = 1'b1;
    repeat (4) tick();
    #2;
    RST = 1'b1;
    #1;
    tests_run++;
    if (state !== 2'd0 || pipe_en !== 1'b0 || cycle_count !== 16'd0 || ireg_flush !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got state %0d pipe %b count %0d flush %b want 0/0/0/0",
               state, pipe_en, cycle_count, ireg_flush);
    end
    step_btn = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd2 || cycle_count !== 16'd0) begin
      tests_failed++; $display("FAIL post_reset_step: got state %0d count %0d want 2/0", state, cycle_count);
    end
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pipe_en !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL post_reset_no_pulse: got %0d advances want 0", bad); end
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests_run++;
      if (pipe_en !== (k == 7)) begin
        tests_failed++; $display("FAIL repress_k%0d: got %b want %b", k, pipe_en, (k == 7));
      end
    end
    step_btn = 1'b0;
    tests_run++;
    if (cycle_count !== 16'd1) begin tests_failed++; $display("FAIL repress_count: got %0d want 1", cycle_count); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_load_run();
    test_halt();
    test_jump();
    test_step();
    test_reload();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
